pipe_rr_arbiter: RTL and testbench

PIPE_RR_ARBITER -- requirements
Module: pipe_rr_arbiter

---
 rtl/pipe_rr_arbiter.sv | 97 +++++++++
 tb/tb_pipe_rr_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined unit among N_REQ
// requesters; a tag shift register routes each result back to its owner.
module pipe_rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int WIDTH = 8,
  parameter int LAT   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_REQ-1:0]       req_vld,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_rdy,
  output logic                   pipe_in_vld,
  output logic [WIDTH-1:0]       pipe_in_data,
  input  logic                   pipe_out_vld,
  input  logic [WIDTH-1:0]       pipe_out_data,
  output logic [N_REQ-1:0]       res_vld,
  output logic [WIDTH-1:0]       res_data,
  output logic                   tag_err
);

  localparam int TW = $clog2(N_REQ);

  logic [TW-1:0]    last_grant;
  logic [TW-1:0]    win;
  logic [TW-1:0]    idx;
  logic             found;
  logic [N_REQ-1:0] grant;
  logic             issue;
  logic [LAT-1:0]   tv;
  logic [TW-1:0]    tg [LAT];
  logic             exit_vld;
  logic [TW-1:0]    exit_tag;

  // Search starts one past the previous winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = TW'((int'(last_grant) + k) % N_REQ);
      if (!found && req_vld[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (en && rst && found) grant[win] = 1'b1;
  end

  always_comb begin
    pipe_in_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) pipe_in_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign req_rdy     = grant;
  assign issue       = |(req_vld & grant);
  assign pipe_in_vld = issue;

  assign exit_vld = tv[LAT-1];
  assign exit_tag = tg[LAT-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      tv         <= '0;
      last_grant <= TW'(N_REQ - 1);
      tag_err    <= 1'b0;
    end else begin
      tv[0] <= issue;
      for (int i = 1; i < LAT; i++) tv[i] <= tv[i-1];
      if (issue) last_grant <= win;
      if (pipe_out_vld != exit_vld) tag_err <= 1'b1;
    end
  end

  // Tag payload only advances alongside a valid entry.
  always_ff @(posedge clk) begin
    if (issue) tg[0] <= win;
    for (int i = 1; i < LAT; i++) begin
      if (tv[i-1]) tg[i] <= tg[i-1];
    end
  end

  always_comb begin
    res_vld = '0;
    if (rst && pipe_out_vld && exit_vld) res_vld[exit_tag] = 1'b1;
  end

  assign res_data = pipe_out_vld ? pipe_out_data : '0;

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Scoreboard bench for pipe_rr_arbiter: directed grant vectors plus a
// data+1 latency model of the shared unit.
module tb_pipe_rr_arbiter;

  localparam int N = 3;
  localparam int W = 8;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic [N-1:0]   req_vld = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_rdy;
  logic           pipe_in_vld;
  logic [W-1:0]   pipe_in_data;
  logic           pipe_out_vld;
  logic [W-1:0]   pipe_out_data;
  logic [N-1:0]   res_vld;
  logic [W-1:0]   res_data;
  logic           tag_err;

  logic           inj = 1'b0;
  logic [L-1:0]   dv = '0;
  logic [W-1:0]   dd [L];

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [N-1:0] rdy;
    logic [W-1:0] d;
    logic         err;
  } exp_t;

  typedef struct {
    logic [N-1:0] oh;
    logic [W-1:0] d;
    int           due;
  } res_t;

  exp_t exp_q [$];
  res_t res_q [$];

  pipe_rr_arbiter #(.N_REQ(N), .WIDTH(W), .LAT(L)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .req_vld(req_vld),
    .req_data(req_data),
    .req_rdy(req_rdy),
    .pipe_in_vld(pipe_in_vld),
    .pipe_in_data(pipe_in_data),
    .pipe_out_vld(pipe_out_vld),
    .pipe_out_data(pipe_out_data),
    .res_vld(res_vld),
    .res_data(res_data),
    .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared unit model: fixed latency L, result = operand + 1.
  always @(posedge clk) begin
    dv    <= {dv[L-2:0], pipe_in_vld};
    dd[0] <= pipe_in_data + 8'd1;
    for (int i = 1; i < L; i++) dd[i] <= dd[i-1];
  end

  assign pipe_out_vld  = dv[L-1] | inj;
  assign pipe_out_data = inj ? 8'hEE : dd[L-1];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h cycle %0d", nm, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per stepped cycle; routes results.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("req_rdy", 32'(req_rdy), 32'(e.rdy));
      chk("pipe_in_vld", 32'(pipe_in_vld), 32'(|e.rdy));
      chk("pipe_in_data", 32'(pipe_in_data), 32'(e.d));
      chk("tag_err", 32'(tag_err), 32'(e.err));
    end
    if (res_vld != '0) begin
      if (res_q.size() == 0) begin
        chk("res_unexpected", 32'(res_vld), 32'd0);
      end else begin
        res_t r;
        r = res_q.pop_front();
        chk("res_vld", 32'(res_vld), 32'(r.oh));
        chk("res_data", 32'(res_data), 32'(r.d));
        chk("res_cycle", 32'(cyc), 32'(r.due));
      end
    end else if (res_q.size() > 0 && res_q[0].due <= cyc) begin
      res_t r;
      r = res_q.pop_front();
      chk("res_missing", 32'(res_vld), 32'(r.oh));
    end
  end

  task automatic step(input logic r, input logic e, input logic [N-1:0] v,
                      input logic [N-1:0] x_rdy, input logic x_err,
                      input logic i_j, input logic keep);
    exp_t  x;
    res_t  rr;
    @(posedge clk);
    #1;
    rst     = r;
    en      = e;
    req_vld = v;
    inj     = i_j;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(cyc * 4 + i);
    x.rdy = x_rdy;
    x.d   = '0;
    x.err = x_err;
    for (int i = 0; i < N; i++) if (x_rdy[i]) x.d = W'(cyc * 4 + i);
    exp_q.push_back(x);
    if (keep && x_rdy != '0) begin
      rr.oh  = x_rdy;
      rr.d   = x.d + 8'd1;
      rr.due = cyc + L;
      res_q.push_back(rr);
    end
  endtask

  initial begin
    // reset
    step(0, 1, 3'b111, 3'b000, 0, 0, 1);
    step(0, 1, 3'b111, 3'b000, 0, 0, 1);
    // full contention: 0,1,2,0,1,2
    step(1, 1, 3'b111, 3'b001, 0, 0, 1);
    step(1, 1, 3'b111, 3'b010, 0, 0, 1);
    step(1, 1, 3'b111, 3'b100, 0, 0, 1);
    step(1, 1, 3'b111, 3'b001, 0, 0, 1);
    step(1, 1, 3'b111, 3'b010, 0, 0, 1);
    step(1, 1, 3'b111, 3'b100, 0, 0, 1);
    // requester 1 idle: 0,2,0,2
    step(1, 1, 3'b101, 3'b001, 0, 0, 1);
    step(1, 1, 3'b101, 3'b100, 0, 0, 1);
    step(1, 1, 3'b101, 3'b001, 0, 0, 1);
    step(1, 1, 3'b101, 3'b100, 0, 0, 1);
    // enable low while results drain
    step(1, 0, 3'b111, 3'b000, 0, 0, 1);
    step(1, 0, 3'b111, 3'b000, 0, 0, 1);
    step(1, 0, 3'b111, 3'b000, 0, 0, 1);
    // resume after last_grant=2
    step(1, 1, 3'b111, 3'b001, 0, 0, 1);
    step(1, 1, 3'b111, 3'b010, 0, 0, 1);
    step(1, 1, 3'b010, 3'b010, 0, 0, 1);
    step(1, 1, 3'b000, 3'b000, 0, 0, 1);
    step(1, 1, 3'b100, 3'b100, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 1, 3'b000, 3'b000, 0, 0, 1);
    // stray result with empty tag pipe
    step(1, 1, 3'b000, 3'b000, 0, 1, 1);
    step(1, 1, 3'b000, 3'b000, 1, 0, 1);
    step(1, 1, 3'b000, 3'b000, 1, 0, 1);
    // three issues then reset: results dropped
    step(1, 1, 3'b111, 3'b001, 1, 0, 0);
    step(1, 1, 3'b111, 3'b010, 1, 0, 0);
    step(1, 1, 3'b111, 3'b100, 1, 0, 0);
    step(0, 1, 3'b111, 3'b000, 1, 0, 0);
    step(1, 1, 3'b111, 3'b001, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 3'b000, 3'b000, 1, 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("res_q_empty", 32'(res_q.size()), 32'd0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
